// File: rtl/sensor_scheduler_if.sv
// Command, sensor-array and UART-TX signals of the sensor scheduler.
// The master modport is the scheduler and the slave modport is the surrounding logic.
interface sensor_scheduler_if #(
  parameter int unsigned N_SENSORS = 4
);
  logic                      cmd_valid;
  logic [15:0]               cmd;
  logic                      cmd_ready;
  logic [N_SENSORS-1:0]      sinal_request;
  logic [15:0]               comando;
  logic [N_SENSORS-1:0]      buffer_pronto;
  logic [16*N_SENSORS-1:0]   info_bus;
  logic [N_SENSORS-1:0]      buffer_usado;
  logic                      tx_ready;
  logic                      tx_start;
  logic [7:0]                tx_data;

  modport master (
    input  cmd_valid, cmd, buffer_pronto, info_bus, tx_ready,
    output cmd_ready, sinal_request, comando, buffer_usado, tx_start, tx_data
  );

  modport slave (
    output cmd_valid, cmd, buffer_pronto, info_bus, tx_ready,
    input  cmd_ready, sinal_request, comando, buffer_usado, tx_start, tx_data
  );
endinterface

// File: rtl/sensor_scheduler.sv
// Routes commands to DHT11 sensor controllers and serialises their 16-bit responses
// over a shared UART, arbitrating round-robin among controllers with a ready buffer.
module sensor_scheduler #(
  parameter int unsigned N_SENSORS = 4,
  parameter logic [3:0]  ERR_CODE  = 4'b1110
) (
  input  logic clk,
  input  logic rst_n,
  sensor_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    SCAN, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI, RELEASE
  } state_t;

  state_t state, stateNext;

  logic [4:0]           rrPtr, rrPtrNext;
  logic [4:0]           grant, grantNext;
  logic                 grantValid, grantValidNext;
  logic [15:0]          frame, frameNext;
  logic                 waitArmed, waitArmedNext;
  logic                 txStartNext;
  logic [7:0]           txDataNext;
  logic [N_SENSORS-1:0] usadoNext;

  logic                 errPending, errClear;
  logic [15:0]          errFrame;
  logic                 cmdAccept, addrValid;
  logic [4:0]           cmdAddr;
  logic [N_SENSORS-1:0] reqOneHot, grantOneHot;
  logic                 prontoGrant;

  logic                 found;
  logic [4:0]           foundIdx;
  logic [15:0]          foundInfo;
  int unsigned          idx;

  assign bus.cmd_ready = ~errPending;
  assign cmdAccept     = bus.cmd_valid & ~errPending;
  assign cmdAddr       = bus.cmd[4:0];

  always_comb begin
    reqOneHot   = '0;
    grantOneHot = '0;
    prontoGrant = 1'b0;
    addrValid   = (32'(cmdAddr) < N_SENSORS);
    for (int unsigned i = 0; i < N_SENSORS; i++) begin
      if (cmdAddr == 5'(i)) reqOneHot[i] = 1'b1;
      if (grant == 5'(i)) begin
        grantOneHot[i] = 1'b1;
        prontoGrant    = bus.buffer_pronto[i];
      end
    end
  end

  // First ready controller walking upward from rrPtr, wrapping at N_SENSORS.
  always_comb begin
    found     = 1'b0;
    foundIdx  = '0;
    foundInfo = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N_SENSORS; k++) begin
      idx = 32'(rrPtr) + k;
      if (idx >= N_SENSORS) idx = idx - N_SENSORS;
      for (int unsigned i = 0; i < N_SENSORS; i++) begin
        if (!found && idx == i && bus.buffer_pronto[i]) begin
          found     = 1'b1;
          foundIdx  = 5'(i);
          foundInfo = bus.info_bus[16*i +: 16];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.comando       <= '0;
      bus.sinal_request <= '0;
      errPending        <= 1'b0;
      errFrame          <= '0;
    end else begin
      bus.sinal_request <= '0;
      if (errClear) errPending <= 1'b0;
      if (cmdAccept) begin
        bus.comando <= bus.cmd;
        if (addrValid) begin
          bus.sinal_request <= reqOneHot;
        end else begin
          errPending <= 1'b1;
          errFrame   <= {7'b0, ERR_CODE, cmdAddr};
        end
      end
    end
  end

  always_comb begin
    stateNext      = state;
    rrPtrNext      = rrPtr;
    grantNext      = grant;
    grantValidNext = grantValid;
    frameNext      = frame;
    waitArmedNext  = 1'b0;
    txStartNext    = 1'b0;
    txDataNext     = '0;
    usadoNext      = '0;
    errClear       = 1'b0;
    case (state)
      SCAN: begin
        if (errPending) begin
          frameNext      = errFrame;
          grantValidNext = 1'b0;
          stateNext      = SEND_LO;
        end else if (found) begin
          frameNext      = foundInfo;
          grantNext      = foundIdx;
          grantValidNext = 1'b1;
          stateNext      = SEND_LO;
        end
      end
      SEND_LO: begin
        if (bus.tx_ready) begin
          txStartNext = 1'b1;
          txDataNext  = frame[7:0];
          stateNext   = WAIT_LO;
        end
      end
      // waitArmed is low on the first wait cycle, while the UART has not yet seen tx_start.
      WAIT_LO: begin
        if (waitArmed && bus.tx_ready) stateNext = SEND_HI;
        else waitArmedNext = 1'b1;
      end
      SEND_HI: begin
        if (bus.tx_ready) begin
          txStartNext = 1'b1;
          txDataNext  = frame[15:8];
          stateNext   = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (waitArmed && bus.tx_ready) begin
          if (grantValid) begin
            stateNext = RELEASE;
            usadoNext = grantOneHot;
          end else begin
            stateNext = SCAN;
            errClear  = 1'b1;
          end
        end else begin
          waitArmedNext = 1'b1;
        end
      end
      RELEASE: begin
        if (!prontoGrant) begin
          stateNext = SCAN;
          rrPtrNext = (32'(grant) + 1 >= N_SENSORS) ? '0 : grant + 5'd1;
        end else begin
          usadoNext = grantOneHot;
        end
      end
      default: stateNext = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= SCAN;
      rrPtr            <= '0;
      grant            <= '0;
      grantValid       <= 1'b0;
      frame            <= '0;
      waitArmed        <= 1'b0;
      bus.tx_start     <= 1'b0;
      bus.tx_data      <= '0;
      bus.buffer_usado <= '0;
    end else begin
      state            <= stateNext;
      rrPtr            <= rrPtrNext;
      grant            <= grantNext;
      grantValid       <= grantValidNext;
      frame            <= frameNext;
      waitArmed        <= waitArmedNext;
      bus.tx_start     <= txStartNext;
      bus.tx_data      <= txDataNext;
      bus.buffer_usado <= usadoNext;
    end
  end

endmodule

// File: tb/tb_sensor_scheduler.sv
// Directed and randomized checks of sensor_scheduler against a transaction-level
// model of round-robin service order, frame bytes, releases and error frames.
module tb_sensor_scheduler;

  localparam int N = 4;

  logic clk;
  logic rst_n;

  sensor_scheduler_if #(.N_SENSORS(N)) bus ();

  sensor_scheduler #(.N_SENSORS(N), .ERR_CODE(4'b1110)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          nCmp = 0;
  int          nErr = 0;
  logic [7:0]  rxBytes[$];
  logic [3:0]  usadoQ[$];
  logic [3:0]  usadoPrev;
  logic [15:0] info[N];
  int          busy;
  bit          late;
  bit          holdTx;
  bit          autoDrop;
  bit          reraise;
  logic [3:0]  reraiseMask;
  int          rrModel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nextGrant(input logic [3:0] mask, input int rr);
    for (int k = 0; k < N; k++) begin
      if (mask[(rr + k) % N]) return (rr + k) % N;
    end
    return 0;
  endfunction

  // One clock; sample outputs 1 time unit after the edge and advance the UART/sensor models.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.tx_start) begin
      check("tx_start_while_busy", 32'(busy), 0);
      rxBytes.push_back(bus.tx_data);
      busy = $urandom_range(2, 5);
      late = 1'($urandom_range(0, 1));
    end else begin
      late = 1'b0;
      if (busy > 0) busy--;
    end
    bus.tx_ready = !holdTx && (busy == 0 || late);
    if (bus.buffer_usado != '0 && usadoPrev == '0) usadoQ.push_back(bus.buffer_usado);
    usadoPrev = bus.buffer_usado;
    for (int i = 0; i < N; i++) begin
      if (autoDrop && bus.buffer_usado[i]) begin
        bus.buffer_pronto[i] = 1'b0;
        if (reraise) reraiseMask[i] = 1'b1;
      end else if (reraiseMask[i] && !bus.buffer_usado[i]) begin
        bus.buffer_pronto[i] = 1'b1;
        reraiseMask[i] = 1'b0;
      end
    end
  endtask

  task automatic waitBytes(input int n);
    for (int t = 0; t < 600 && rxBytes.size() < n; t++) step();
    if (rxBytes.size() < n) check("timeout_bytes", 32'(rxBytes.size()), 32'(n));
  endtask

  task automatic waitUsado();
    for (int t = 0; t < 600 && usadoQ.size() == 0; t++) step();
    if (usadoQ.size() == 0) check("timeout_usado", 32'(usadoQ.size()), 1);
  endtask

  task automatic setInfo(input int i, input logic [15:0] v);
    info[i] = v;
    bus.info_bus[16*i +: 16] = v;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    bus.buffer_pronto = '0;
    bus.cmd_valid = 1'b0;
    holdTx = 1'b0;
    busy = 0;
    late = 1'b0;
    reraise = 1'b0;
    reraiseMask = '0;
    bus.tx_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    rxBytes.delete();
    usadoQ.delete();
    usadoPrev = '0;
    rrModel = 0;
  endtask

  // Expected service: circular order over the raised set, starting at the model pointer.
  task automatic serve(input logic [3:0] maskIn);
    logic [3:0] m;
    logic [7:0] lo, hi;
    int g;
    m = maskIn;
    while (m != '0) begin
      g = nextGrant(m, rrModel);
      waitBytes(1);
      bus.info_bus[16*g +: 16] = 16'($urandom);
      waitBytes(2);
      lo = rxBytes.pop_front();
      hi = rxBytes.pop_front();
      check("frame", {hi, lo}, info[g]);
      waitUsado();
      check("grant", usadoQ.pop_front(), 32'(1) << g);
      m[g] = 1'b0;
      rrModel = (g + 1) % N;
    end
    step();
    step();
  endtask

  initial begin
    logic [3:0]  mask;
    logic [4:0]  addr;
    logic [15:0] c;
    logic [7:0]  lo, hi;

    clk = 1'b0;
    rst_n = 1'b0;
    bus.cmd = '0;
    bus.cmd_valid = 1'b0;
    bus.info_bus = '0;
    bus.buffer_pronto = '0;
    bus.tx_ready = 1'b1;
    autoDrop = 1'b1;
    usadoPrev = '0;
    resetDut();

    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_sinal_request", bus.sinal_request, 0);
    check("rst_comando", bus.comando, 0);
    check("rst_buffer_usado", bus.buffer_usado, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);

    // Command routing to sensor 2
    bus.cmd = 16'h0302;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    check("req_strobe", bus.sinal_request, 4'b0100);
    check("req_comando", bus.comando, 16'h0302);
    step();
    check("req_one_cycle", bus.sinal_request, 0);

    // Single controller, latency and release handshake
    autoDrop = 1'b0;
    setInfo(1, 16'hA5C3);
    bus.buffer_pronto = 4'b0010;
    step();
    check("lat_no_start_yet", bus.tx_start, 0);
    step();
    check("lat_start", bus.tx_start, 1);
    check("lat_byte_lo", bus.tx_data, 8'hC3);
    waitBytes(2);
    check("byte_hi", rxBytes[1], 8'hA5);
    waitUsado();
    check("usado_sensor1", usadoQ.pop_front(), 4'b0010);
    for (int t = 0; t < 3; t++) begin
      step();
      check("usado_held", bus.buffer_usado, 4'b0010);
    end
    bus.buffer_pronto = 4'b0000;
    step();
    check("usado_dropped", bus.buffer_usado, 0);
    autoDrop = 1'b1;

    // Round robin with controllers re-raising after release
    resetDut();
    for (int i = 0; i < N; i++) setInfo(i, 16'($urandom));
    reraise = 1'b1;
    bus.buffer_pronto = 4'b1011;
    for (int t = 0; t < 2000 && usadoQ.size() < 4; t++) step();
    check("rr_count", 32'(usadoQ.size() >= 4), 1);
    check("rr_g0", usadoQ[0], 4'b0001);
    check("rr_g1", usadoQ[1], 4'b0010);
    check("rr_g2", usadoQ[2], 4'b1000);
    check("rr_g3", usadoQ[3], 4'b0001);
    resetDut();

    // Command to a non-existent sensor produces an error frame
    bus.cmd = 16'h0007;
    bus.cmd_valid = 1'b1;
    step();
    check("err_no_strobe", bus.sinal_request, 0);
    check("err_comando", bus.comando, 16'h0007);
    check("err_ready_low", bus.cmd_ready, 0);
    bus.cmd = 16'h0001;
    step();
    bus.cmd_valid = 1'b0;
    check("err_blocked_strobe", bus.sinal_request, 0);
    check("err_blocked_comando", bus.comando, 16'h0007);
    waitBytes(2);
    check("err_byte_lo", rxBytes[0], 8'hC7);
    check("err_byte_hi", rxBytes[1], 8'h01);
    rxBytes.delete();
    for (int t = 0; t < 200 && !bus.cmd_ready; t++) step();
    check("err_ready_back", bus.cmd_ready, 1);
    check("err_no_usado", 32'(usadoQ.size()), 0);

    // UART held busy while a frame waits in SEND_LO
    setInfo(0, 16'($urandom));
    holdTx = 1'b1;
    bus.tx_ready = 1'b0;
    bus.buffer_pronto = 4'b0001;
    for (int t = 0; t < 100; t++) begin
      step();
      check("hold_no_start", bus.tx_start, 0);
    end
    holdTx = 1'b0;
    bus.tx_ready = 1'b1;
    step();
    check("hold_resume_start", bus.tx_start, 1);
    check("hold_resume_byte", bus.tx_data, info[0][7:0]);
    waitBytes(2);
    lo = rxBytes.pop_front();
    hi = rxBytes.pop_front();
    check("hold_frame", {hi, lo}, info[0]);
    waitUsado();
    check("hold_usado", usadoQ.pop_front(), 4'b0001);
    rrModel = 1;
    step();
    step();

    // Reset while the high byte is in flight
    setInfo(1, 16'($urandom));
    bus.buffer_pronto = 4'b0010;
    serve(4'b0010);
    setInfo(2, 16'($urandom));
    bus.buffer_pronto = 4'b0100;
    waitBytes(2);
    rst_n = 1'b0;
    step();
    check("midrst_tx_start", bus.tx_start, 0);
    check("midrst_tx_data", bus.tx_data, 0);
    check("midrst_usado", bus.buffer_usado, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 1);
    check("midrst_comando", bus.comando, 0);
    rst_n = 1'b1;
    rxBytes.delete();
    usadoQ.delete();
    rrModel = 0;
    setInfo(1, 16'($urandom));
    setInfo(3, 16'($urandom));
    bus.buffer_pronto = 4'b1010;
    serve(4'b1010);

    // Randomized rounds, each with a command accepted alongside the grant
    for (int r = 0; r < 10; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) setInfo(i, 16'($urandom));
      addr = 5'($urandom_range(0, N - 1));
      c = {11'($urandom), addr};
      bus.cmd = c;
      bus.cmd_valid = 1'b1;
      bus.buffer_pronto = mask;
      step();
      bus.cmd_valid = 1'b0;
      check("rnd_strobe", bus.sinal_request, 32'(1) << addr);
      check("rnd_comando", bus.comando, c);
      serve(mask);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
